tx_redundancy_scheduler: RTL and testbench

- Sequences the transmit-side packet builder so that every data segment goes out `redundancy` times. The receive-side majority voter depends on this.
- Issues one start command per packet carrying segment number, copy id and aux (frame) number, then waits for the builder's completion pulse.
- Enforces the inter-packet gap and the inter-round gap.
- Loop order, outermost first: aux, then id (1..redundancy), then segment (0..SEGMENT_NUM_MAX-1).

---
 rtl/tx_redundancy_scheduler_pkg.sv | 30 +++
 rtl/tx_redundancy_scheduler_gap_timer.sv | 32 +++
 rtl/tx_redundancy_scheduler.sv | 163 ++++++++++++++++
 tb/tb_tx_redundancy_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_redundancy_scheduler_pkg.sv
// Shared types, defaults and width helpers for the transmit redundancy scheduler.
// Counter widths are derived from the timing parameters so they never overflow.
package tx_redundancy_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_ISSUE,
    ST_WAIT,
    ST_RGAP
  } state_e;

  localparam int ID_FIRST             = 1;
  localparam int SEGMENT_NUM_MAX_DEF  = 5;
  localparam int GAP_PKT_DEF          = 10;
  localparam int GAP_ROUND_DEF        = 30;
  localparam int DONE_TIMEOUT_DEF     = 1024;

  function automatic int gap_cnt_w(input int gap_pkt, input int gap_round);
    return $clog2(((gap_pkt > gap_round) ? gap_pkt : gap_round) + 1);
  endfunction

  function automatic int tmo_cnt_w(input int done_timeout);
    return $clog2(done_timeout + 1);
  endfunction

  localparam int GAP_CNT_W_DEF = gap_cnt_w(GAP_PKT_DEF, GAP_ROUND_DEF);
  localparam int TMO_CNT_W_DEF = tmo_cnt_w(DONE_TIMEOUT_DEF);

endpackage

// File: rtl/tx_redundancy_scheduler_gap_timer.sv
// Loadable down-counter shared by the packet gap and the round gap.
// Loading N makes done rise after N further cycles, so a load of (gap-1) spans gap cycles.
module tx_redundancy_scheduler_gap_timer
  import tx_redundancy_scheduler_pkg::*;
#(
  parameter int W = GAP_CNT_W_DEF
) (
  input  logic         clk125MHz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk125MHz) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tx_redundancy_scheduler.sv
// Drives the packet builder so every segment is sent `redundancy` times per frame,
// spacing packets and rounds and force-completing packets the builder never finishes.
module tx_redundancy_scheduler
  import tx_redundancy_scheduler_pkg::*;
#(
  parameter int SEGMENT_NUM_MAX = SEGMENT_NUM_MAX_DEF,
  parameter int GAP_PKT         = GAP_PKT_DEF,
  parameter int GAP_ROUND       = GAP_ROUND_DEF,
  parameter int DONE_TIMEOUT    = DONE_TIMEOUT_DEF
) (
  input  logic        clk125MHz,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  redundancy,
  output logic        pkt_start,
  output logic [15:0] pkt_seg,
  output logic [7:0]  pkt_id,
  output logic [7:0]  pkt_aux,
  input  logic        pkt_done,
  output logic        frame_done,
  output logic        active,
  output logic        timeout_err
);

  localparam int GW = gap_cnt_w(GAP_PKT, GAP_ROUND);
  localparam int TW = tmo_cnt_w(DONE_TIMEOUT);
  localparam logic [GW-1:0] GAP_PKT_LD   = GW'(GAP_PKT - 1);
  localparam logic [GW-1:0] GAP_ROUND_LD = GW'(GAP_ROUND - 1);
  localparam logic [15:0]   SEG_LAST     = 16'(SEGMENT_NUM_MAX - 1);
  localparam logic [TW-1:0] TMO_LIMIT    = TW'(DONE_TIMEOUT);
  localparam logic [7:0]    ID_ONE       = 8'(ID_FIRST);

  state_e        state_q, state_d;
  logic [15:0]   seg_q, seg_d;
  logic [7:0]    id_q, id_d;
  logic [7:0]    aux_q, aux_d;
  logic [7:0]    red_q, red_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          pkt_start_q, pkt_start_d;
  logic          frame_done_q, frame_done_d;
  logic          active_q, active_d;
  logic          tmo_err_q, tmo_err_d;

  logic          tmr_load;
  logic [GW-1:0] tmr_val;
  logic          tmr_done;
  logic          timeout;

  tx_redundancy_scheduler_gap_timer #(.W(GW)) u_gap_timer (
    .clk125MHz (clk125MHz),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .done      (tmr_done)
  );

  // wcnt counts WAIT cycles including the current one, so WAIT lasts at most DONE_TIMEOUT cycles.
  assign timeout = (wcnt_q == TMO_LIMIT);

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    id_d         = id_q;
    aux_d        = aux_q;
    red_d        = red_q;
    wcnt_d       = wcnt_q;
    tmo_err_d    = tmo_err_q;
    pkt_start_d  = 1'b0;
    frame_done_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = GAP_PKT_LD;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          red_d    = (redundancy == 8'd0) ? ID_ONE : redundancy;
          seg_d    = '0;
          id_d     = ID_ONE;
          tmr_load = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP, ST_RGAP: begin
        if (tmr_done) begin
          pkt_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = TW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pkt_done || timeout) begin
          if (timeout) tmo_err_d = 1'b1;
          if (seg_q < SEG_LAST) begin
            seg_d    = seg_q + 16'd1;
            tmr_load = 1'b1;
            state_d  = ST_GAP;
          end else if (id_q < red_q) begin
            seg_d    = '0;
            id_d     = id_q + 8'd1;
            tmr_load = 1'b1;
            tmr_val  = GAP_ROUND_LD;
            state_d  = ST_RGAP;
          end else begin
            // Frame complete; enable only decides whether another frame follows.
            seg_d        = '0;
            id_d         = ID_ONE;
            aux_d        = aux_q + 8'd1;
            frame_done_d = 1'b1;
            if (enable) begin
              tmr_load = 1'b1;
              state_d  = ST_GAP;
            end else begin
              state_d  = ST_IDLE;
            end
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk125MHz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      seg_q        <= '0;
      id_q         <= ID_ONE;
      aux_q        <= '0;
      red_q        <= ID_ONE;
      wcnt_q       <= '0;
      pkt_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      active_q     <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      id_q         <= id_d;
      aux_q        <= aux_d;
      red_q        <= red_d;
      wcnt_q       <= wcnt_d;
      pkt_start_q  <= pkt_start_d;
      frame_done_q <= frame_done_d;
      active_q     <= active_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  assign pkt_start   = pkt_start_q;
  assign pkt_seg     = seg_q;
  assign pkt_id      = id_q;
  assign pkt_aux     = aux_q;
  assign frame_done  = frame_done_q;
  assign active      = active_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_tx_redundancy_scheduler.sv
// Scoreboard bench: stimulus queues the expected packet order per frame; a monitor
// with an embedded builder model checks order, gap timing, frame_done and aux.
module tb_tx_redundancy_scheduler;

  localparam int SEG_N   = 5;
  localparam int GAP_P   = 11;   // pkt_start follows the done cycle by GAP_PKT+1
  localparam int GAP_R   = 31;   // and by GAP_ROUND+1 after a round ends
  localparam int TMO     = 1024;

  logic        clk125MHz = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  redundancy = 8'd0;
  logic        pkt_done = 1'b0;
  logic        pkt_start;
  logic [15:0] pkt_seg;
  logic [7:0]  pkt_id, pkt_aux;
  logic        frame_done, active, timeout_err;

  always #4 clk125MHz = ~clk125MHz;

  tx_redundancy_scheduler dut (
    .clk125MHz   (clk125MHz),
    .reset       (reset),
    .enable      (enable),
    .redundancy  (redundancy),
    .pkt_start   (pkt_start),
    .pkt_seg     (pkt_seg),
    .pkt_id      (pkt_id),
    .pkt_aux     (pkt_aux),
    .pkt_done    (pkt_done),
    .frame_done  (frame_done),
    .active      (active),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int seg;
    int id;
    int aux;
    int gap;
    bit last;
  } pkt_t;

  pkt_t sb[$];
  pkt_t cur;
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, ref_cyc = 0;
  int   n_starts = 0, n_frames = 0, exp_frames = 0, exp_aux = 0;
  int   dly_lo = 577, dly_hi = 577;
  int   wh_seg = -1, wh_id = -1;
  bit   spur_en = 1'b0;
  bit   pend = 1'b0, fd_pend = 1'b0;
  int   done_at = 0, spur_at = -1, fd_aux = 0;

  always @(posedge clk125MHz) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected frame contents straight from the loop order: id outer, segment inner.
  task automatic push_frame(input int r);
    pkt_t p;
    for (int id = 1; id <= r; id++)
      for (int s = 0; s < SEG_N; s++) begin
        p.seg  = s;
        p.id   = id;
        p.aux  = exp_aux;
        p.gap  = (s == 0 && id > 1) ? GAP_R : GAP_P;
        p.last = (s == SEG_N - 1) && (id == r);
        sb.push_back(p);
      end
    exp_aux = (exp_aux + 1) % 256;
    exp_frames++;
  endtask

  // Monitor plus builder model; the model's done cycle becomes the gap reference.
  initial begin : monitor
    int d;
    forever begin
      @(negedge clk125MHz);
      pkt_done = 1'b0;
      if (pkt_start === 1'b1) begin
        n_starts++;
        if (sb.size() == 0) begin
          chk("unexpected_start", sb.size(), 1);
        end else begin
          cur = sb.pop_front();
          chk("start_seg", pkt_seg, cur.seg);
          chk("start_id", pkt_id, cur.id);
          chk("start_aux", pkt_aux, cur.aux);
          chk("start_gap", cyc - ref_cyc, cur.gap);
          if (cur.last) begin
            fd_pend = 1'b1;
            fd_aux  = (cur.aux + 1) % 256;
          end
          if (cur.seg == wh_seg && cur.id == wh_id) begin
            ref_cyc = cyc + TMO;
            wh_seg  = -1;
          end else begin
            d       = $urandom_range(dly_hi, dly_lo);
            pend    = 1'b1;
            done_at = cyc + d;
            ref_cyc = done_at;
          end
        end
      end else if (pend && cyc == done_at) begin
        pkt_done = 1'b1;
        pend     = 1'b0;
        chk("hold_seg", pkt_seg, cur.seg);
        chk("hold_id", pkt_id, cur.id);
        if (spur_en) spur_at = cyc + 3;
      end else if (cyc == spur_at) begin
        pkt_done = 1'b1;
        spur_at  = -1;
      end
      if (frame_done === 1'b1) begin
        n_frames++;
        chk("frame_done_expected", fd_pend, 1);
        chk("frame_done_cyc", cyc - ref_cyc, 1);
        chk("frame_aux", pkt_aux, fd_aux);
        fd_pend = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk125MHz);
    #1;
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_starts", (n_starts >= n), 1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (n_frames < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_frames", (n_frames >= n), 1);
  endtask

  task automatic go(input logic [7:0] r);
    chk("idle_before_run", active, 0);
    redundancy = r;
    enable     = 1'b1;
    ref_cyc    = cyc;
  endtask

  task automatic chk_reset_vals();
    chk("rst_pkt_start", pkt_start, 0);
    chk("rst_pkt_seg", pkt_seg, 0);
    chk("rst_pkt_id", pkt_id, 1);
    chk("rst_pkt_aux", pkt_aux, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_active", active, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  initial begin : stim
    int base;
    reset = 1'b1;
    repeat (3) step();
    chk_reset_vals();
    reset = 1'b0;
    step();

    // redundancy 3, slow builder; redundancy input changed mid-frame must not matter
    dly_lo = 577; dly_hi = 577;
    push_frame(3);
    go(8'd3);
    wait_starts(1, 100);
    enable = 1'b0;
    repeat (50) step();
    redundancy = 8'd2;
    wait_frames(1, 20000);
    step();
    chk("t1_active", active, 0);
    chk("t1_aux", pkt_aux, 1);
    chk("t1_tmo", timeout_err, 0);

    // redundancy 0 behaves as 1
    dly_lo = 1; dly_hi = 20;
    push_frame(1);
    go(8'd0);
    wait_starts(n_starts + 1, 100);
    enable = 1'b0;
    wait_frames(2, 2000);
    step();
    chk("t3_active", active, 0);
    chk("t3_aux", pkt_aux, 2);

    // builder withholds (seg 2, id 1); spurious done pulses in GAP
    dly_lo = 1; dly_hi = 30;
    spur_en = 1'b1;
    wh_seg = 2; wh_id = 1;
    push_frame(2);
    base = n_starts;
    go(8'd2);
    wait_starts(base + 1, 100);
    enable = 1'b0;
    wait_starts(base + 3, 500);
    chk("t4_tmo_before", timeout_err, 0);
    repeat (1000) step();
    chk("t4_tmo_not_yet", timeout_err, 0);
    repeat (30) step();
    chk("t4_tmo_set", timeout_err, 1);
    wait_frames(3, 3000);
    spur_en = 1'b0;
    step();
    chk("t4_active", active, 0);
    chk("t4_aux", pkt_aux, 3);

    // 257 back-to-back frames starting at aux 3: wraps through 255 -> 0, ends on aux 3
    dly_lo = 1; dly_hi = 3;
    for (int f = 0; f < 257; f++) push_frame(1);
    go(8'd1);
    wait_frames(3 + 256, 40000);
    enable = 1'b0;
    wait_frames(3 + 257, 500);
    step();
    chk("t5_active", active, 0);
    chk("t5_aux", pkt_aux, 4);
    chk("t5_tmo_sticky", timeout_err, 1);

    // reset while waiting on (seg 2, id 2)
    dly_lo = 577; dly_hi = 577;
    push_frame(2);
    base = n_starts;
    go(8'd2);
    wait_starts(base + 8, 6000);
    repeat (20) step();
    chk("t6_in_flight_id", pkt_id, 2);
    reset = 1'b1;
    enable = 1'b0;
    sb.delete();
    pend = 1'b0;
    fd_pend = 1'b0;
    spur_at = -1;
    exp_aux = 0;
    exp_frames--;
    step();
    chk_reset_vals();
    reset = 1'b0;
    repeat (60) step();
    chk("final_frames", n_frames, exp_frames);
    chk("final_active", active, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
